// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency memory handshake
// and hands each instruction to decode, then steers the PC from the execute-path result.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic [1:0]            PCSrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  misalign
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_HALT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_valid;
  logic                  r_misalign;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_next_pc;

  // Branch offsets are two's complement, so the add wraps modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] calc_next_pc(
    input logic [1:0]            src,
    input logic [DATA_WIDTH-1:0] cur_pc,
    input logic signed [DATA_WIDTH-1:0] imm,
    input logic [DATA_WIDTH-1:0] alu
  );
    logic [DATA_WIDTH-1:0] nxt;
    case (src)
      2'b01:   nxt = DATA_WIDTH'($signed(cur_pc) + imm);
      2'b10:   nxt = {alu[DATA_WIDTH-1:1], 1'b0};
      default: nxt = cur_pc + DATA_WIDTH'(4);
    endcase
    return nxt;
  endfunction

  assign w_accept  = r_valid & instr_ready;
  assign w_next_pc = calc_next_pc(PCSrc, r_pc, $signed(ImmExt), ALUResult);

  // The request strobe is decoded from S_REQ so the first fetch lands in the first
  // cycle out of reset; gating with rst keeps it low while reset is held.
  assign imem_req    = (r_state == S_REQ) & ~rst;
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + DATA_WIDTH'(4);
  assign misalign    = r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end
        end
        S_VALID: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            // A misaligned target leaves pc pointing at the faulting instruction.
            if (w_next_pc[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
              r_state    <= S_HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= S_REQ;
            end
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests with ~addr,
// request and accept monitors pop expected addresses queued by the directed stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        misalign;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat   = 1;
  logic [31:0] exp_req[$];
  logic [31:0] exp_acc[$];

  fetch_unit #(.RESET_PC(32'hBFC00000), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .misalign(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory model and request monitor: response word is the bitwise inverse of the address.
  initial begin
    int          cnt;
    logic [31:0] m_addr;
    logic        prev_req;
    cnt = 0; m_addr = '0; prev_req = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        imem_rvalid = 1'b0;
        prev_req = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~m_addr;
          end
        end
        if (imem_req) begin
          chk("req_single_pulse", {31'd0, prev_req}, 32'd0);
          if (exp_req.size() == 0) chk("unexpected_req", imem_addr, 32'hDEADDEAD);
          else chk("req_addr", imem_addr, exp_req.pop_front());
          m_addr = imem_addr;
          cnt    = lat;
        end
        prev_req = imem_req;
      end
    end
  end

  // Accept monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (instr_valid && instr_ready) begin
        if (exp_acc.size() == 0) chk("unexpected_accept", pc, 32'hDEADDEAD);
        else begin
          e = exp_acc.pop_front();
          chk("acc_pc", pc, e);
          chk("acc_instr", instr, ~e);
          chk("acc_pc_plus4", pc_plus4, e + 32'd4);
        end
      end
    end
  end

  task automatic do_accept(input logic [1:0] src, input logic [31:0] imm,
                           input logic [31:0] alu, input int stall);
    int          n;
    logic [31:0] h_i, h_p;
    n = 0;
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      chk("valid_timeout", 32'd0, 32'd1);
      return;
    end
    h_i = instr;
    h_p = pc;
    for (int s = 0; s < stall; s++) begin
      instr_ready = 1'b0;
      PCSrc       = 2'($urandom);
      ImmExt      = $urandom;
      ALUResult   = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instr, h_i);
      chk("hold_pc", pc, h_p);
    end
    PCSrc = src; ImmExt = imm; ALUResult = alu; instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    rst = 1'b1; instr_ready = 1'b0; PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;
    last = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'hBFC00000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);

    // Sequential fetch with ready held high.
    exp_req.push_back(32'hBFC00000); exp_req.push_back(32'hBFC00004);
    exp_req.push_back(32'hBFC00008); exp_req.push_back(32'hBFC0000C);
    exp_req.push_back(32'hBFC00010);
    exp_acc.push_back(32'hBFC00000); exp_acc.push_back(32'hBFC00004);
    exp_acc.push_back(32'hBFC00008); exp_acc.push_back(32'hBFC0000C);
    instr_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!instr_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("seq_valid_seen", {31'd0, instr_valid}, 32'd1);
      if (k > 0) chk("seq_gap_cycles", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    @(negedge clk);
    instr_ready = 1'b0;

    // Branches: backward then forward from BFC00010.
    exp_acc.push_back(32'hBFC00010); exp_req.push_back(32'hBFC00008);
    do_accept(2'b01, 32'hFFFFFFF8, 32'd0, 0);
    exp_acc.push_back(32'hBFC00008); exp_req.push_back(32'hBFC0000C);
    do_accept(2'b00, 32'd0, 32'd0, 0);
    exp_acc.push_back(32'hBFC0000C); exp_req.push_back(32'hBFC00010);
    do_accept(2'b11, 32'h00000040, 32'h00000103, 0);
    exp_acc.push_back(32'hBFC00010); exp_req.push_back(32'hBFC00110);
    do_accept(2'b01, 32'h00000100, 32'd0, 0);

    // JALR clears bit 0; next fetch has 4-cycle latency and 5 stall cycles.
    lat = 4;
    exp_acc.push_back(32'hBFC00110); exp_req.push_back(32'h00000204);
    do_accept(2'b10, 32'd0, 32'h00000205, 0);
    exp_acc.push_back(32'h00000204);
    do_accept(2'b10, 32'd0, 32'h00000102, 5);
    for (int h = 0; h < 5; h++) begin
      chk("halt_misalign", {31'd0, misalign}, 32'd1);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_pc", pc, 32'h00000204);
      @(negedge clk);
    end

    rst = 1'b1;
    @(negedge clk);
    chk("rst2_misalign", {31'd0, misalign}, 32'd0);
    chk("rst2_pc", pc, 32'hBFC00000);
    lat = 1;
    exp_req.push_back(32'hBFC00000); exp_acc.push_back(32'hBFC00000);
    @(posedge clk); #1 rst = 1'b0;

    // Wrap-around at the top of the address space.
    exp_req.push_back(32'hFFFFFFFC);
    do_accept(2'b10, 32'd0, 32'hFFFFFFFD, 0);
    exp_acc.push_back(32'hFFFFFFFC); exp_req.push_back(32'h00000000);
    do_accept(2'b00, 32'd0, 32'd0, 0);
    lat = 4;
    exp_acc.push_back(32'h00000000); exp_req.push_back(32'h00000004);
    do_accept(2'b00, 32'd0, 32'd0, 0);

    // Reset while waiting on memory.
    @(negedge clk);
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    chk("wait_pc", pc, 32'h00000004);
    rst = 1'b1;
    @(negedge clk);
    chk("rst3_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst3_pc", pc, 32'hBFC00000);
    lat = 1;
    exp_req.push_back(32'hBFC00000); exp_acc.push_back(32'hBFC00000);
    @(posedge clk); #1 rst = 1'b0;
    exp_req.push_back(32'hBFC00004);
    do_accept(2'b00, 32'd0, 32'd0, 0);
    repeat (4) @(negedge clk);

    chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
    chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
